or3_vector_sweeper: RTL and testbench
=====================================

# or3_vector_sweeper

Self-checking stimulus stage for the three-input OR gate block: drives its `a`, `b`, `c` inputs through all eight combinations 000→111, waits a settle window per vector, samples the gate's `d` (intermediate a|b) and `y` (a|b|c) outputs, and scores them against expected values. It sits directly upstream of the gate (feeding its inputs) and closes the loop on the gate's outputs. Used on the lab board to replace hand-toggled switches with a repeatable sweep and pass/fail indication.

## Interface
- `SETTLE_CYCLES`, default 4, clock cycles each vector is held before sampling; legal range 1..255.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level sampled each cycle; begins a sweep when idle.
- `d_in`  in  1  gate intermediate output (expected a|b).
- `y_in`  in  1  gate final output (expected a|b|c).
- `a`, `b`, `c`  out  1 each  gate stimulus; `{a,b,c}` = current vector index.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `done`  out  1  one-cycle pulse at sweep end.
- `err_cnt`  out  4  number of failing vectors in the last sweep, 0..8.
- `pass`  out  1  high after done when err_cnt==0; held until next start.
- `fail_valid`  out  1  at least one vector failed this sweep.
- `first_fail_vec`  out  3  index of first failing vector; valid when fail_valid.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset (async, rst_n=0): state IDLE; a=b=c=0, busy=0, done=0, err_cnt=0, pass=0, fail_valid=0, first_fail_vec=0, settle counter 0.
- IDLE: start=1 → vec←0, err_cnt←0, pass←0, fail_valid←0, counter←0, busy←1, go SETTLE.
- SETTLE: counter increments each cycle; at counter==SETTLE_CYCLES-1 go SAMPLE.
- SAMPLE (one cycle): expected_d = vec[2]|vec[1], expected_y = |vec. If d_in≠expected_d or y_in≠expected_y, vector fails: err_cnt+1 (max 8, no overflow in 4 bits); first fail latches first_fail_vec←vec, fail_valid←1. If vec==7 go DONE, else vec←vec+1, counter←0, go SETTLE.
- DONE: done=1 one cycle, busy←0, pass←(err_cnt==0), go IDLE.
- start during busy or DONE ignored; no queueing. start held high in IDLE re-triggers a new sweep each time the block returns to IDLE.
- Result outputs hold until the next accepted start.

## Timing
- start sampled at edge 0 → busy and a/b/c=000 valid from cycle 1.
- Each vector occupies SETTLE_CYCLES+1 cycles; a/b/c change only on SAMPLE→SETTLE transitions.
- done high in cycle 8·(SETTLE_CYCLES+1)+1 after start (cycle 41 for default 4); pass/busy update same edge as done.
- d_in/y_in sampled only in SAMPLE, registered; no combinational path inputs→outputs.
- Reset mid-sweep: immediate return to reset values, no done pulse.

## Configuration
- `OR3_SELF_CHECK_EN` defined: comparison, err_cnt, pass, fail_valid, first_fail_vec as above.
- Not defined: sweep and done/busy timing identical; d_in/y_in unused; err_cnt, pass, fail_valid, first_fail_vec tied 0.

## Structure
- Package `or3_sweep_pkg`: state enum, `VEC_LAST` = 3'd7, `ERR_W` = 4, expected-value function.
- Sub-module `settle_timer`: counter with load/clear and terminal-count flag, parameterised by SETTLE_CYCLES.

## Test plan
- Correct gate model, SETTLE_CYCLES=4, start pulse at cycle 0 → a/b/c step 000..111 every 5 cycles, done at cycle 41, err_cnt=0, pass=1, fail_valid=0.
- y_in stuck at 0 → vectors 001..111 fail: err_cnt=7, first_fail_vec=001, pass=0.
- d_in stuck at 1 → vectors 000, 001 fail: err_cnt=2, first_fail_vec=000.
- start re-pulsed at cycle 10 during sweep → ignored, done still at cycle 41, single sweep.
- rst_n low at cycle 15 → all outputs reset same cycle, no done; fresh start then completes normally.
- Build without OR3_SELF_CHECK_EN, y_in stuck at 0 → done at cycle 41, err_cnt=0, pass=0.

Source files
------------

// File: rtl/or3_sweep_pkg.sv
// Shared state encoding, sweep constants and the reference gate function
// used by the three-input OR gate stimulus sweeper.
package or3_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    localparam logic [2:0] VEC_LAST = 3'd7;
    localparam int         ERR_W    = 4;
    localparam logic [ERR_W-1:0] ERR_MAX = 4'd8;

    // Returns {expected d, expected y} for a vector ordered {a,b,c}.
    function automatic logic [1:0] or3_expect(input logic [2:0] vec);
        return {vec[2] | vec[1], |vec};
    endfunction

endpackage

// File: rtl/or3_vector_sweeper_settle_timer.sv
// Per-vector settle counter: clear wins over count-enable, tc_o flags the last
// settle cycle (count == SETTLE_CYCLES-1). One-cycle registered count, no backpressure.
module settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [7:0] TC_VAL = 8'(SETTLE_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/or3_vector_sweeper.sv
// Sweeps {a,b,c} through 000..111, holding each SETTLE_CYCLES then sampling d_in/y_in;
// done pulses 8*(SETTLE_CYCLES+1) cycles after start is accepted. start is ignored while busy/done.
// Scoring (err_cnt, pass, fail_valid, first_fail_vec) only exists when OR3_SELF_CHECK_EN is defined.
module or3_vector_sweeper
    import or3_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             d_in,
    input  logic             y_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt,
    output logic             pass,
    output logic             fail_valid,
    output logic [2:0]       first_fail_vec
);

    sweep_state_e state_q, state_d;
    logic [2:0]   vec_q, vec_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         tmr_clr, tmr_en, tmr_tc;
    logic         start_acc, in_sample, last_vec;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    assign start_acc = (state_q == ST_IDLE) && start;
    assign in_sample = (state_q == ST_SAMPLE);
    assign last_vec  = (vec_q == VEC_LAST);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d   = 3'd0;
                    busy_d  = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_tc) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                tmr_clr = 1'b1;
                // done rises on the same edge busy drops and pass settles
                if (last_vec) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {a, b, c} = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef OR3_SELF_CHECK_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             pass_q, pass_d;
    logic             fail_valid_q, fail_valid_d;
    logic [2:0]       first_fail_q, first_fail_d;
    logic             mismatch;

    assign mismatch = ({d_in, y_in} != or3_expect(vec_q));

    always_comb begin
        err_cnt_d    = err_cnt_q;
        pass_d       = pass_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        if (start_acc) begin
            err_cnt_d    = '0;
            pass_d       = 1'b0;
            fail_valid_d = 1'b0;
        end else if (in_sample) begin
            if (mismatch) begin
                if (err_cnt_q != ERR_MAX) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                end
                if (!fail_valid_q) begin
                    fail_valid_d = 1'b1;
                    first_fail_d = vec_q;
                end
            end
            if (last_vec) begin
                pass_d = (err_cnt_d == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q    <= '0;
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            first_fail_q <= 3'd0;
        end else begin
            err_cnt_q    <= err_cnt_d;
            pass_q       <= pass_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign err_cnt        = err_cnt_q;
    assign pass           = pass_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_vec = first_fail_q;
`else
    logic unused_gate_inputs;
    assign unused_gate_inputs = d_in ^ y_in ^ start_acc ^ in_sample;

    assign err_cnt        = '0;
    assign pass           = 1'b0;
    assign fail_valid     = 1'b0;
    assign first_fail_vec = 3'd0;
`endif

endmodule

// File: tb/tb_or3_vector_sweeper.sv
// Bench for or3_vector_sweeper: closes the loop through a faultable OR3 gate model
// and scores vector timing, done timing and sweep results against a scoreboard.
module tb_or3_vector_sweeper;

    localparam int SC       = 4;
    localparam int VEC_CYC  = SC + 1;
    localparam int DONE_REL = 8 * VEC_CYC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       d_in, y_in;
    logic       a, b, c, busy, done, pass, fail_valid;
    logic [3:0] err_cnt;
    logic [2:0] first_fail_vec;

    // 0 good gate, 1 y stuck-at-0, 2 d stuck-at-1, 3 both outputs inverted
    int fault = 0;

    assign d_in = (fault == 2) ? 1'b1 : (fault == 3) ? ~(a | b)     : (a | b);
    assign y_in = (fault == 1) ? 1'b0 : (fault == 3) ? ~(a | b | c) : (a | b | c);

    or3_vector_sweeper #(.SETTLE_CYCLES(SC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .d_in           (d_in),
        .y_in           (y_in),
        .a              (a),
        .b              (b),
        .c              (c),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .pass           (pass),
        .fail_valid     (fail_valid),
        .first_fail_vec (first_fail_vec)
    );

    always #5 clk = ~clk;

    typedef struct { int vec; int rel; } vec_exp_t;
    typedef struct { int err; int pass; int fv; int ffv; int done_rel; } res_exp_t;
    typedef struct { string name; int flt; int repulse_rel; int err; int ffv; } case_t;

    vec_exp_t vq[$];
    res_exp_t rq[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag, input res_exp_t r);
        check({tag, "/err_cnt"}, int'(err_cnt), r.err);
        check({tag, "/pass"}, int'(pass), r.pass);
        check({tag, "/fail_valid"}, int'(fail_valid), r.fv);
        if (r.fv != 0) check({tag, "/first_fail_vec"}, int'(first_fail_vec), r.ffv);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "/abc"}, int'({a, b, c}), 0);
        check({tag, "/busy"}, int'(busy), 0);
        check({tag, "/done"}, int'(done), 0);
        check({tag, "/err_cnt"}, int'(err_cnt), 0);
        check({tag, "/pass"}, int'(pass), 0);
        check({tag, "/fail_valid"}, int'(fail_valid), 0);
        check({tag, "/first_fail_vec"}, int'(first_fail_vec), 0);
    endtask

    task automatic run_sweep(input case_t tc);
        res_exp_t r, got;
        vec_exp_t e;
        int done_cnt, prev_abc, abc;
        bit busy_ok;
        fault = tc.flt;
        for (int i = 0; i < 8; i++) vq.push_back('{i, i * VEC_CYC});
`ifdef OR3_SELF_CHECK_EN
        r = '{tc.err, int'(tc.err == 0), int'(tc.err != 0), tc.ffv, DONE_REL};
`else
        r = '{0, 0, 0, 0, DONE_REL};
`endif
        rq.push_back(r);
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0;
        busy_ok  = 1'b1;
        prev_abc = -1;
        for (int k = 0; k <= DONE_REL + 10; k++) begin
            abc = int'({a, b, c});
            if (k == 0 || abc != prev_abc) begin
                if (vq.size() == 0) begin
                    check({tc.name, "/unexpected_vec_change"}, k, -1);
                end else begin
                    e = vq.pop_front();
                    check({tc.name, "/vec_value"}, abc, e.vec);
                    check({tc.name, "/vec_cycle"}, k, e.rel);
                end
            end
            prev_abc = abc;
            if (busy != (k < DONE_REL)) busy_ok = 1'b0;
            if (done) begin
                done_cnt++;
                if (rq.size() != 0) begin
                    got = rq.pop_front();
                    check({tc.name, "/done_cycle"}, k, got.done_rel);
                    check_results(tc.name, got);
                end
            end
            start = (k == tc.repulse_rel - 1);
            tick();
        end
        start = 1'b0;
        check({tc.name, "/done_pulses"}, done_cnt, 1);
        check({tc.name, "/busy_window"}, int'(busy_ok), 1);
        check({tc.name, "/vec_missing"}, vq.size(), 0);
        check({tc.name, "/done_timeout"}, rq.size(), 0);
        check_results({tc.name, "_hold"}, r);
        vq.delete();
        rq.delete();
    endtask

    initial begin
        case_t tbl[5];
        int dq[$];
        int done_cnt;

        tbl[0] = '{"good",            0, -1, 0, 0};
        tbl[1] = '{"y_stuck0",        1, -1, 7, 1};
        tbl[2] = '{"d_stuck1",        2, -1, 2, 0};
        tbl[3] = '{"inverted",        3, -1, 8, 0};
        tbl[4] = '{"restart_ignored", 0, 10, 0, 0};

        #2;
        check_reset_outs("reset");
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_sweep(tbl[i]);

        // start held high: ignored in DONE, re-accepted once back in IDLE
        fault = 0;
        dq.push_back(DONE_REL);
        dq.push_back(2 * DONE_REL + 2);
        @(negedge clk);
        start = 1'b1;
        tick();
        done_cnt = 0;
        for (int k = 0; k <= 2 * DONE_REL + 12; k++) begin
            if (k == DONE_REL + 1) check("retrigger/busy_idle", int'(busy), 0);
            if (k == DONE_REL + 2) check("retrigger/busy_restart", int'(busy), 1);
            if (done) begin
                done_cnt++;
                if (dq.size() != 0) check("retrigger/done_cycle", k, dq.pop_front());
                else check("retrigger/extra_done", k, -1);
            end
            if (k == DONE_REL + 2) start = 1'b0;
            tick();
        end
        start = 1'b0;
        check("retrigger/done_pulses", done_cnt, 2);
        check("retrigger/pass", int'(pass), 
`ifdef OR3_SELF_CHECK_EN
            1
`else
            0
`endif
        );

        // asynchronous reset in the middle of a failing sweep
        fault = 1;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        check("midreset/busy_before", int'(busy), 1);
`ifdef OR3_SELF_CHECK_EN
        check("midreset/err_before", int'(err_cnt), 1);
        check("midreset/ffv_before", int'(first_fail_vec), 1);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midreset");
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < DONE_REL + 10; k++) begin
            if (done) done_cnt++;
            tick();
        end
        check("midreset/no_done", done_cnt, 0);
        check("midreset/idle_busy", int'(busy), 0);
        run_sweep('{"after_reset", 0, -1, 0, 0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
